quad_select_arbiter: RTL and testbench

// - Round-robin arbiter that shares one 2-to-4 decoder between 4 requesters.
// - Picks one requester, drives the decoder select and gates the decoder's one-hot outputs into grant strobes.
// - Holds each grant until the owner releases it.
// - Sits between the cell-update engines and the shared board-bank select path.

---
 rtl/quad_select_arbiter_if.sv | 23 ++
 rtl/quad_select_arbiter.sv | 128 ++++++++++++
 tb/tb_quad_select_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/quad_select_arbiter_if.sv
// Handshake bundle between the cell-update engines and the quad select arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface quad_select_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic       grant_valid;
  logic [1:0] grant_sel;
  logic       grant_00;
  logic       grant_01;
  logic       grant_10;
  logic       grant_11;
  logic       timeout;

  modport master (
    output req, done,
    input  grant_valid, grant_sel, grant_00, grant_01, grant_10, grant_11, timeout
  );

  modport slave (
    input  req, done,
    output grant_valid, grant_sel, grant_00, grant_01, grant_10, grant_11, timeout
  );
endinterface

// File: rtl/quad_select_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 board-bank decoder among 4 requesters.
// A grant is held until the owner pulses done or drops its request; one dead
// cycle always separates two grants.
// Optional feature: define QUAD_ARB_TIMEOUT_EN to force release after HOLD_LIMIT
// cycles of ownership and pulse timeout for one cycle.

// Shared 2-to-4 bank-select decoder (val_in -> one-hot val_xx).
module quad_select_decoder (
  input  logic [1:0] val_in,
  output logic       val_00,
  output logic       val_01,
  output logic       val_10,
  output logic       val_11
);
  assign val_00 = (val_in == 2'b00);
  assign val_01 = (val_in == 2'b01);
  assign val_10 = (val_in == 2'b10);
  assign val_11 = (val_in == 2'b11);
endmodule

module quad_select_arbiter #(
  parameter int HOLD_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  quad_select_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic       valid_q;
  logic [1:0] sel_q;
  logic [1:0] last_sel;
  logic       timeout_q;
  logic [1:0] next_sel;
  logic [1:0] probe;
  logic       release_now;
  logic       limit_hit;
  logic       dec_00, dec_01, dec_10, dec_11;

  // Round-robin pick: first requester after last_sel (offsets 1..4); scanning
  // offsets downward lets the nearest set bit overwrite farther ones.
  always_comb begin
    next_sel = last_sel;
    probe    = last_sel;
    for (int k = 4; k >= 1; k--) begin
      probe = last_sel + 2'(k);
      if (bus.req[probe]) next_sel = probe;
    end
  end

  // Owner lets go either explicitly or by withdrawing its request.
  assign release_now = bus.done || !bus.req[sel_q];

`ifdef QUAD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_LIMIT) + 1;
  logic [CW-1:0] hold_cnt;

  assign limit_hit = (state == GRANT) && (hold_cnt == CW'(HOLD_LIMIT - 1));

  // Ownership-age counter: zero on the first GRANT cycle, counts while held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (!release_now && !limit_hit) begin
      hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // Arbitration FSM with registered grant, owner index and timeout pulse.
  // NOTE: reset is asynchronous so the grant drops the instant reset rises,
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      sel_q     <= 2'b00;
      last_sel  <= 2'b11;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      timeout_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            sel_q   <= next_sel;
            valid_q <= 1'b1;
            state   <= GRANT;
          end else begin
            valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now || limit_hit) begin
            last_sel  <= sel_q;
            valid_q   <= 1'b0;
            state     <= IDLE;
            timeout_q <= !release_now;
          end
        end
      endcase
    end
  end

  quad_select_decoder u_dec (
    .val_in (sel_q),
    .val_00 (dec_00),
    .val_01 (dec_01),
    .val_10 (dec_10),
    .val_11 (dec_11)
  );

  assign bus.grant_valid = valid_q;
  assign bus.grant_sel   = sel_q;
  assign bus.grant_00    = dec_00 & valid_q;
  assign bus.grant_01    = dec_01 & valid_q;
  assign bus.grant_10    = dec_10 & valid_q;
  assign bus.grant_11    = dec_11 & valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_quad_select_arbiter.sv
// Bench for quad_select_arbiter: directed scenarios with literal expectations,
// then random req/done/reset traffic checked every cycle against a behavioural
// model. Define QUAD_ARB_TIMEOUT_EN for both bench and design to cover timeout.
module tb_quad_select_arbiter;

  localparam int HOLD_LIMIT = 16;
`ifdef QUAD_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   checking = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  quad_select_arbiter_if bus ();

  quad_select_arbiter #(.HOLD_LIMIT(HOLD_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one cycle; returns just after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.grant_11, bus.grant_10, bus.grant_01, bus.grant_00};
  endfunction

  // ---------------- behavioural model ----------------
  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_last  = 3;
  bit m_to    = 1'b0;
  int m_held  = 0;   // cycles the current grant has been visible

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0; m_sel = 0; m_last = 3; m_to = 1'b0; m_held = 0;
    end else begin
      m_to = 1'b0;
      if (m_valid) begin
        if (bus.done || !bus.req[m_sel]) begin
          m_last = m_sel; m_valid = 1'b0;
        end else if (TIMEOUT_ON && m_held == HOLD_LIMIT) begin
          m_last = m_sel; m_valid = 1'b0; m_to = 1'b1;
        end else begin
          m_held++;
        end
      end else if (bus.req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (bus.req[(m_last + k) % 4]) begin
            m_sel = (m_last + k) % 4;
            break;
          end
        end
        m_valid = 1'b1;
        m_held  = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("model_valid",   32'(bus.grant_valid), 32'(m_valid));
      check("model_sel",     32'(bus.grant_sel),   32'(m_sel));
      check("model_strobes", 32'(strobes()),       m_valid ? 32'(1 << m_sel) : 32'd0);
      check("model_timeout", 32'(bus.timeout),     32'(m_to));
    end
  end

  // Expect a visible grant on s this cycle, then release it with done.
  task automatic grant_then_done(input logic [1:0] s, input string tag);
    cyc();
    check({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    check({tag, "_sel"},   32'(bus.grant_sel),   32'(s));
    check({tag, "_onehot"}, 32'(strobes()),      32'(4'b0001 << s));
    bus.done = 1'b1;
    cyc();
    check({tag, "_dead"},  32'(bus.grant_valid), 32'd0);
    bus.done = 1'b0;
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #2 reset = 1'b1;
    #1 checking = 1'b1;
    repeat (3) cyc();
    check("rst_valid",   32'(bus.grant_valid), 32'd0);
    check("rst_strobes", 32'(strobes()),       32'd0);
    check("rst_sel",     32'(bus.grant_sel),   32'd0);
    check("rst_timeout", 32'(bus.timeout),     32'd0);
    reset = 1'b0;
    cyc();
    check("idle_valid",  32'(bus.grant_valid), 32'd0);

    // All requesting: rotation 0,1,2,3,0 with one dead cycle each.
    bus.req = 4'b1111;
    grant_then_done(2'd0, "rr0");
    grant_then_done(2'd1, "rr1");
    grant_then_done(2'd2, "rr2");
    grant_then_done(2'd3, "rr3");
    grant_then_done(2'd0, "rr4");

    // Lone requester 2, then withdrawal releases it.
    bus.req = 4'b0100;
    cyc();
    check("solo_sel",  32'(bus.grant_sel), 32'd2);
    check("solo_g10",  32'(bus.grant_10),  32'd1);
    bus.req = 4'b0000;
    cyc();
    check("withdraw_valid", 32'(bus.grant_valid), 32'd0);
    // last_sel is now 2: search starts at 3.
    bus.req = 4'b1011;
    cyc();
    check("after_withdraw_sel", 32'(bus.grant_sel), 32'd3);
    bus.done = 1'b1; bus.req = 4'b0010;
    cyc();
    bus.done = 1'b0;
    cyc();
    check("own01_sel", 32'(bus.grant_sel), 32'd1);
    // Release and new requests together: release wins, then search from 2.
    bus.done = 1'b1; bus.req = 4'b1001;
    cyc();
    check("coincide_dead", 32'(bus.grant_valid), 32'd0);
    bus.done = 1'b0;
    cyc();
    check("coincide_sel", 32'(bus.grant_sel), 32'd3);
    check("coincide_g11", 32'(bus.grant_11),  32'd1);

    // Async reset mid-grant drops everything immediately.
    #2 reset = 1'b1;
    #1;
    check("async_valid",   32'(bus.grant_valid), 32'd0);
    check("async_strobes", 32'(strobes()),       32'd0);
    bus.req = 4'b1111;
    cyc();
    reset = 1'b0;
    cyc();
    check("post_rst_sel", 32'(bus.grant_sel), 32'd0);
    check("post_rst_g00", 32'(bus.grant_00),  32'd1);

    // Long hold with requesters 0 and 1, done never asserted.
    bus.req = 4'b0000;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.req = 4'b0011;
    cyc();
    check("hold_first_sel", 32'(bus.grant_sel), 32'd0);
`ifdef QUAD_ARB_TIMEOUT_EN
    repeat (HOLD_LIMIT - 1) cyc();
    check("hold_last_valid", 32'(bus.grant_valid), 32'd1);
    check("hold_last_sel",   32'(bus.grant_sel),   32'd0);
    cyc();
    check("to_dead_valid", 32'(bus.grant_valid), 32'd0);
    check("to_pulse",      32'(bus.timeout),     32'd1);
    cyc();
    check("to_next_sel",   32'(bus.grant_sel),   32'd1);
    check("to_cleared",    32'(bus.timeout),     32'd0);
`else
    repeat (99) cyc();
    check("hold100_valid",   32'(bus.grant_valid), 32'd1);
    check("hold100_sel",     32'(bus.grant_sel),   32'd0);
    check("hold100_timeout", 32'(bus.timeout),     32'd0);
`endif

    // Random traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.req  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      bus.done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        cyc();
        reset = 1'b0;
      end else begin
        cyc();
      end
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
